window_3x3_gen: RTL and testbench

//  Raster-stream to 3x3 neighbourhood generator; sits directly upstream of GaussianBlur.

---
 rtl/window_3x3_gen_pkg.sv | 7 +
 rtl/window_3x3_gen_line_buffer.sv | 25 ++
 rtl/window_3x3_gen.sv | 113 +++++++++++
 tb/tb_window_3x3_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_gen_pkg.sv
// Shared image geometry defaults for the 3x3 window generator.
// Optional feature macro: WIN_COORD_EN (adds win_x/win_y outputs).
package window_3x3_gen_pkg;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int PIX_W_DEF = 8;
endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One line of pixel storage: combinational read, synchronous write,
// so a same-cycle read returns the old contents.
module line_buffer
  import window_3x3_gen_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int DEPTH = IMG_W_DEF,
  parameter int AW    = $clog2(IMG_W_DEF)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             we,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster stream to 3x3 neighbourhood generator with two line buffers.
// Define WIN_COORD_EN to add the win_x/win_y centre-coordinate outputs.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] lu,
  output logic [PIX_W-1:0] cu,
  output logic [PIX_W-1:0] ru,
  output logic [PIX_W-1:0] lc,
  output logic [PIX_W-1:0] cc,
  output logic [PIX_W-1:0] rc,
  output logic [PIX_W-1:0] lb,
  output logic [PIX_W-1:0] cb,
  output logic [PIX_W-1:0] rb,
`ifdef WIN_COORD_EN
  output logic [COL_W-1:0] win_x,
  output logic [ROW_W-1:0] win_y,
`endif
  output logic             win_valid
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col, pcol;
  logic [ROW_W-1:0] row, prow;
  logic [PIX_W-1:0] up, mid;
  logic             interior;

  // sof forces the accepted pixel to (0,0) regardless of the counters
  assign pcol = sof ? '0 : col;
  assign prow = sof ? '0 : row;
  assign interior = (pcol >= COL_W'(2)) && (prow >= ROW_W'(2));

  line_buffer #(
    .PIX_W(PIX_W),
    .DEPTH(IMG_W),
    .AW   (COL_W)
  ) lbuf0 (
    .clk  (clk),
    .addr (pcol),
    .wdata(mid),
    .we   (pix_valid),
    .rdata(up)
  );

  line_buffer #(
    .PIX_W(PIX_W),
    .DEPTH(IMG_W),
    .AW   (COL_W)
  ) lbuf1 (
    .clk  (clk),
    .addr (pcol),
    .wdata(pix_in),
    .we   (pix_valid),
    .rdata(mid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (pcol == COL_LAST) begin
        col <= '0;
        row <= (prow == ROW_LAST) ? '0 : prow + ROW_W'(1);
      end else begin
        col <= pcol + COL_W'(1);
        row <= prow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {lu, cu, ru} <= '0;
      {lc, cc, rc} <= '0;
      {lb, cb, rb} <= '0;
      win_valid    <= 1'b0;
    end else begin
      win_valid <= pix_valid && interior;
      if (pix_valid) begin
        {lu, cu, ru} <= {cu, ru, up};
        {lc, cc, rc} <= {cc, rc, mid};
        {lb, cb, rb} <= {cb, rb, pix_in};
      end
    end
  end

`ifdef WIN_COORD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_x <= '0;
      win_y <= '0;
    end else if (pix_valid) begin
      win_x <= pcol - COL_W'(1);
      win_y <= prow - ROW_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen on a 5x4 image.
// Reference model keeps the current frame as a 2D array indexed by (row,col).
module tb_window_3x3_gen;
  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof;
  logic [7:0] lu, cu, ru, lc, cc, rc, lb, cb, rb;
  logic       win_valid;
`ifdef WIN_COORD_EN
  logic [2:0] win_x;
  logic [1:0] win_y;
`endif

  window_3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .sof      (sof),
    .lu(lu), .cu(cu), .ru(ru),
    .lc(lc), .cc(cc), .rc(rc),
    .lb(lb), .cb(cb), .rb(rb),
`ifdef WIN_COORD_EN
    .win_x    (win_x),
    .win_y    (win_y),
`endif
    .win_valid(win_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       ev;
    logic [7:0] ecc;
  } vec_t;

  vec_t       vec [W*H];
  logic [7:0] img [H][W];
  int         mc, mr;
  int         pulses;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] win_now();
    return {lu, cu, ru, lc, cc, rc, lb, cb, rb};
  endfunction

  // Expected 3x3 neighbourhood whose bottom-right pixel is (c,r)
  function automatic logic [71:0] win_ref(input int c, input int r);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[71 - 8*(dr*3+dc) -: 8] = img[r-2+dr][c-2+dc];
    return w;
  endfunction

  task automatic accept(input logic [7:0] p, input logic s,
                        output logic pulsed);
    int c, r;
    if (s) begin
      mc = 0;
      mr = 0;
    end
    c = mc;
    r = mr;
    img[r][c] = p;
    pix_in = p;
    sof = s;
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof = 1'b0;
    pulsed = (c >= 2) && (r >= 2);
    chk("win_valid", {71'd0, win_valid}, {71'd0, pulsed});
    if (pulsed) begin
      pulses++;
      chk("window", win_now(), win_ref(c, r));
`ifdef WIN_COORD_EN
      chk("win_x", 72'(win_x), 72'(c - 1));
      chk("win_y", 72'(win_y), 72'(r - 1));
`endif
    end
    if (c == W - 1) begin
      mc = 0;
      mr = (r == H - 1) ? 0 : r + 1;
    end else begin
      mc = c + 1;
    end
  endtask

  task automatic idle(input int n, input logic sof_noise);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b0;
      sof = sof_noise;
      @(posedge clk);
      #1;
      sof = 1'b0;
      chk("idle_valid", {71'd0, win_valid}, 72'd0);
    end
  endtask

  logic [7:0]  pat;
  logic        p;
  logic [71:0] held;
  int          first_idx, k;

  initial begin
    rst_n = 1'b0;
    pix_in = '0;
    pix_valid = 1'b0;
    sof = 1'b0;
    mc = 0;
    mr = 0;
    pulses = 0;

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        vec[r*W+c].pix = {r[3:0], c[3:0]};
        vec[r*W+c].sof = (r == 0 && c == 0);
        vec[r*W+c].ev  = (r >= 2 && c >= 2);
        vec[r*W+c].ecc = {4'(r - 1), 4'(c - 1)};
      end

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_window", win_now(), 72'd0);
    chk("reset_valid", {71'd0, win_valid}, 72'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: one continuous frame from the table
    pulses = 0;
    for (int i = 0; i < W*H; i++) begin
      accept(vec[i].pix, vec[i].sof, p);
      if (vec[i].ev) chk("tbl_cc", 72'(cc), 72'(vec[i].ecc));
      if (vec[i].pix == 8'h22)
        chk("first_win", win_now(), 72'h00_01_02_10_11_12_20_21_22);
    end
    chk("last_cc", 72'(cc), 72'h23);
    chk("t2_pulses", 72'(pulses), 72'd6);

    // 3: same frame with random gaps and stray sof while idle
    pulses = 0;
    for (int i = 0; i < W*H; i++) begin
      accept(vec[i].pix, vec[i].sof, p);
      held = win_now();
      idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      chk("hold", win_now(), held);
    end
    chk("t3_pulses", 72'(pulses), 72'd6);

    // 4: two frames back to back, second relies on counter wrap
    pulses = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < W*H; i++) begin
        pat = vec[i].pix + (f == 1 ? 8'h80 : 8'h00);
        accept(pat, (f == 0) && vec[i].sof, p);
        if (f == 1 && pat == 8'hA2) begin
          chk("f2_lu", 72'(lu), 72'h80);
          chk("f2_rb", 72'(rb), 72'hA2);
        end
      end
    chk("t4_pulses", 72'(pulses), 72'd12);

    // 5: mid-frame resync via sof
    for (int i = 0; i < 7; i++) accept(8'($urandom), i == 0, p);
    first_idx = 0;
    k = 1;
    accept(8'h07, 1'b1, p);
    for (k = 2; k <= 16; k++) begin
      accept(8'($urandom), 1'b0, p);
      if (p && first_idx == 0) first_idx = k;
    end
    chk("resync_idx", 72'(first_idx), 72'd13);

    // 6: asynchronous reset mid-frame, then random frame from (0,0)
    for (int i = 0; i < 13; i++) accept(8'($urandom), i == 0, p);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_window", win_now(), 72'd0);
    chk("async_valid", {71'd0, win_valid}, 72'd0);
`ifdef WIN_COORD_EN
    chk("async_xy", 72'({win_x, win_y}), 72'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    mc = 0;
    mr = 0;
    pulses = 0;
    for (int i = 0; i < W*H; i++) begin
      accept(8'($urandom), 1'b0, p);
      if ($urandom_range(0, 2) == 0) idle(1, 1'b0);
    end
    chk("t6_pulses", 72'(pulses), 72'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
